dma_channel_arbiter: RTL
========================

// Module: dma_channel_arbiter
// PURPOSE
//  Channel request arbiter and bus-hold sequencer for the DMA controller.
//  Samples per-channel DREQ, applies mask/polarity, raises HRQ to the CPU, and on HLDA grants one channel.
//  Grant is by fixed or rotating priority. Holds DACK until the transfer engine signals service done.
//  Sits between the DREQ pins/command+mask registers and the transfer timing engine.
// PARAMETERS
//  NCH  4            number of DMA channels (power of 2, >=2)
//  CW   $clog2(NCH)  channel index width (derived, do not override)
// PORTS
//  clk            in   1    system clock; all state on rising edge
//  rst            in   1    reset, asynchronous assert, active-low (0 = reset)
//  dreq           in   NCH  raw channel DMA requests
//  mask           in   NCH  1 = channel masked (from mask register)
//  dreq_sense_low in   1    1 = DREQ active-low (command bit 6)
//  dack_sense_hi  in   1    1 = DACK active-high (command bit 7)
//  rot_pri        in   1    1 = rotating priority (command bit 4)
//  ctrl_disable   in   1    1 = controller disabled (command bit 2)
//  hlda           in   1    hold acknowledge from CPU
//  svc_done       in   1    1-cycle pulse from transfer engine: service of granted channel ended (TC/EOP/single)
//  hrq            out  1    hold request to CPU
//  dack           out  NCH  channel acknowledge, polarity per dack_sense_hi, at most one active
//  chan           out  CW   granted channel index; valid while chan_valid
//  chan_valid     out  1    grant active (state ACTIVE)
//  abort          out  1    1-cycle pulse: HLDA lost during ACTIVE
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, hrq=0, dack=all inactive (per current dack_sense_hi), chan=0, chan_valid=0, abort=0, hi_ptr=0, req_q=0.
//  - req_q <= (dreq ^ {NCH{dreq_sense_low}}) every cycle. elig = req_q & ~mask, forced 0 when ctrl_disable.
//  - FSM (registered outputs):
//    IDLE    : |elig -> HREQ; hrq=1 next cycle. Latency dreq edge -> hrq = 2 clocks.
//    HREQ    : hlda & |elig -> ACTIVE; winner = pick(elig, hi_ptr) latched into chan; dack/chan_valid asserted next cycle.
//              !hlda & !|elig -> IDLE, hrq=0. hlda & !|elig -> RELEASE, hrq=0.
//    ACTIVE  : svc_done -> RELEASE: hrq=0, dack inactive, chan_valid=0; if rot_pri, hi_ptr <= chan+1 (mod NCH).
//              !hlda (checked first; wins over simultaneous svc_done) -> IDLE, abort=1 for 1 cycle, no hi_ptr update.
//              DREQ deassertion or mask change in ACTIVE has no effect; grant is held until svc_done/abort.
//    RELEASE : wait hlda=0 -> IDLE. New requests are not acted on until IDLE.
//  - pick(): fixed priority (rot_pri=0): lowest index wins; hi_ptr forced to 0 on every cycle rot_pri=0.
//    Rotating: search starts at hi_ptr, wraps NCH-1 -> 0; first set bit wins.
//  - dack polarity changes apply combinationally to the registered one-hot grant (no extra latency).
//  - ctrl_disable asserted in HREQ behaves as elig=0; in ACTIVE it does not cut the current service.
// CONFIGURATION
//  DMA_ARB_ROTATE_EN defined: behaviour above; rot_pri selects rotating priority.
//  Not defined: rot_pri ignored; fixed priority only; hi_ptr register and rotation logic removed (pick uses 0).
// STRUCTURE
//  Package dma_arb_pkg: arb_state_e {IDLE,HREQ,ACTIVE,RELEASE}, NCH_DEF=4, function pick_rot(elig, hi_ptr) returning index.
//  One sub-module: dma_rot_pri_sel (combinational NCH-way rotating selector; elig, hi_ptr -> idx, any).
// TESTING
//  1 Reset: rst=0 mid-ACTIVE with ch2 granted -> next sample hrq=0, dack=0000 (sense_hi=1), chan_valid=0, hi_ptr=0.
//  2 Fixed: dreq=1010 @N, hlda=1 @N+3 -> hrq=1 @N+2, dack=0010 @N+4; svc_done -> hrq=0, dack=0000 next cycle.
//  3 Rotating: rot_pri=1, dreq=1111 held, 4 services -> grant order 0,1,2,3,0; hi_ptr wraps 3->0.
//  4 Mask/polarity: dreq_sense_low=1, dreq=1110, mask=0001 -> no hrq; mask=0000 -> ch0 granted.
//  5 Abort: hlda drops during ACTIVE with svc_done same cycle -> abort=1 pulse, state IDLE, hi_ptr unchanged.
//  6 Withdraw: dreq removed while in HREQ with hlda=0 -> hrq=0 and IDLE; with hlda=1 -> RELEASE until hlda=0.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg
// Shared types and helpers for the DMA channel arbiter.
//   arb_state_e : arbiter FSM state encoding
//   NCH_DEF     : default channel count
//   pick_rot()  : rotating-priority pick for an NCH_DEF-wide request vector
package dma_arb_pkg;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = $clog2(NCH_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HREQ    = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    // Search starts at hi_ptr and wraps; the first set bit wins.
    function automatic logic [CW_DEF-1:0] pick_rot(input logic [NCH_DEF-1:0] elig,
                                                   input logic [CW_DEF-1:0]  hi_ptr);
        logic [CW_DEF-1:0] c;
        logic              found;
        pick_rot = '0;
        found    = 1'b0;
        for (int i = 0; i < NCH_DEF; i++) begin
            c = hi_ptr + CW_DEF'(i);
            if (!found && elig[c]) begin
                pick_rot = c;
                found    = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/dma_rot_pri_sel.sv
// dma_rot_pri_sel
// Combinational NCH-way rotating priority selector. With hi_ptr_i = 0 it
// degenerates to fixed priority (lowest index wins).
// Ports:
//   elig_i   [NCH]  eligible request vector
//   hi_ptr_i [CW]   index that gets highest priority
//   idx_o    [CW]   winning index (0 when nothing eligible)
//   any_o           at least one request eligible
module dma_rot_pri_sel
    import dma_arb_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic [NCH-1:0]         elig_i,
    input  logic [$clog2(NCH)-1:0] hi_ptr_i,
    output logic [$clog2(NCH)-1:0] idx_o,
    output logic                   any_o
);

    localparam int CW = $clog2(NCH);

    always_comb begin
        logic [CW-1:0] c;
        logic          found;
        c     = '0;
        found = 1'b0;
        idx_o = '0;
        // NCH is a power of two, so the CW-bit add wraps NCH-1 -> 0 for free.
        for (int i = 0; i < NCH; i++) begin
            c = hi_ptr_i + CW'(i);
            if (!found && elig_i[c]) begin
                idx_o = c;
                found = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter
// Channel request arbiter and bus-hold sequencer for the DMA controller.
// Samples DREQ, applies mask/polarity, raises HRQ, grants one channel on HLDA
// and holds DACK until the transfer engine reports service done.
//
// Build option: DMA_ARB_ROTATE_EN enables rotating priority (rot_pri_i);
// without it the arbiter is fixed priority only and rot_pri_i is ignored.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   dreq_i [NCH]             raw channel requests
//   mask_i [NCH]             1 = channel masked
//   dreq_sense_low_i         1 = DREQ active-low
//   dack_sense_hi_i          1 = DACK active-high
//   rot_pri_i                1 = rotating priority
//   ctrl_disable_i           1 = controller disabled
//   hlda_i                   hold acknowledge from CPU
//   svc_done_i               service of granted channel ended (pulse)
//   hrq_o                    hold request to CPU
//   dack_o [NCH]             channel acknowledge, at most one active
//   chan_o [CW]              granted channel index
//   chan_valid_o             grant active
//   abort_o                  pulse: HLDA lost while ACTIVE
//
// state   | meaning
// IDLE    | no request pending
// HREQ    | HRQ raised, waiting for HLDA
// ACTIVE  | channel granted, DACK held until svc_done or HLDA loss
// RELEASE | HRQ dropped, waiting for HLDA to fall
module dma_channel_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NCH-1:0]         dreq_i,
    input  logic [NCH-1:0]         mask_i,
    input  logic                   dreq_sense_low_i,
    input  logic                   dack_sense_hi_i,
    input  logic                   rot_pri_i,
    input  logic                   ctrl_disable_i,
    input  logic                   hlda_i,
    input  logic                   svc_done_i,
    output logic                   hrq_o,
    output logic [NCH-1:0]         dack_o,
    output logic [$clog2(NCH)-1:0] chan_o,
    output logic                   chan_valid_o,
    output logic                   abort_o
);

    localparam int CW = $clog2(NCH);

    arb_state_e     state_q, state_d;
    logic [NCH-1:0] req_q;
    logic [NCH-1:0] elig;
    logic [NCH-1:0] grant_q, grant_d;
    logic [CW-1:0]  chan_q, chan_d;
    logic           hrq_q, hrq_d;
    logic           chan_valid_q, chan_valid_d;
    logic           abort_q, abort_d;
    logic [CW-1:0]  pick_ptr;
    logic [CW-1:0]  sel_idx;
    logic           sel_any;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) req_q <= '0;
        else         req_q <= dreq_i ^ {NCH{dreq_sense_low_i}};
    end

    assign elig = ctrl_disable_i ? '0 : (req_q & ~mask_i);

`ifdef DMA_ARB_ROTATE_EN
    logic [CW-1:0] hi_ptr_q, hi_ptr_d;

    // Pointer only advances on a normal service completion; an abort keeps it.
    always_comb begin
        hi_ptr_d = hi_ptr_q;
        if (!rot_pri_i)
            hi_ptr_d = '0;
        else if (state_q == ACTIVE && hlda_i && svc_done_i)
            hi_ptr_d = chan_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) hi_ptr_q <= '0;
        else         hi_ptr_q <= hi_ptr_d;
    end

    // Mask the pointer in the cycle rot_pri drops, before the register clears.
    assign pick_ptr = rot_pri_i ? hi_ptr_q : '0;
`else
    logic unused_rot_pri;
    assign unused_rot_pri = rot_pri_i;
    assign pick_ptr       = '0;
`endif

    dma_rot_pri_sel #(.NCH(NCH)) u_sel (
        .elig_i   (elig),
        .hi_ptr_i (pick_ptr),
        .idx_o    (sel_idx),
        .any_o    (sel_any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            hrq_q        <= 1'b0;
            grant_q      <= '0;
            chan_q       <= '0;
            chan_valid_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hrq_q        <= hrq_d;
            grant_q      <= grant_d;
            chan_q       <= chan_d;
            chan_valid_q <= chan_valid_d;
            abort_q      <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sel_any) state_d = HREQ;
            end
            HREQ: begin
                if (hlda_i && sel_any) state_d = ACTIVE;
                else if (!sel_any)     state_d = hlda_i ? RELEASE : IDLE;
            end
            ACTIVE: begin
                // Losing HLDA takes precedence over a coincident svc_done.
                if (!hlda_i)         state_d = IDLE;
                else if (svc_done_i) state_d = RELEASE;
            end
            RELEASE: begin
                if (!hlda_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hrq_d        = (state_d == HREQ) || (state_d == ACTIVE);
        chan_valid_d = (state_d == ACTIVE);
        abort_d      = (state_q == ACTIVE) && !hlda_i;
        grant_d      = '0;
        chan_d       = chan_q;
        if (state_q == HREQ && state_d == ACTIVE) begin
            grant_d = {{(NCH-1){1'b0}}, 1'b1} << sel_idx;
            chan_d  = sel_idx;
        end else if (state_d == ACTIVE) begin
            grant_d = grant_q;
        end
    end

    assign hrq_o        = hrq_q;
    assign dack_o       = dack_sense_hi_i ? grant_q : ~grant_q;
    assign chan_o       = chan_q;
    assign chan_valid_o = chan_valid_q;
    assign abort_o      = abort_q;

endmodule
